kfmmc_drive_arbiter: RTL and testbench
======================================

# kfmmc_drive_arbiter

Two-requester arbiter that shares one KFMMC_Drive between two host-side bus agents, e.g. two bus masters or two emulated controller front-ends. It sits between the requesters' register-write interfaces and the drive's internal bus. It grants exclusive ownership round-robin, forwards only the owner's register writes, and routes `read_data`, `interrupt` and `terminal_count` to and from the owner. It holds ownership while the drive is busy and preempts an owner that idles while the other side waits.

## Interface
- `max_hold_cycles`, default 16'd1024: idle-owner cycles, with the other side requesting, before forced release.
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `req_0`, `req_1`  in  1  requester wants the drive (level).
- `gnt_0`, `gnt_1`  out  1  ownership grant (registered, one-hot or zero).
- `wr_0`, `wr_1`  in  1  register write strobe (1 cycle).
- `sel_0`, `sel_1`  in  3  target register:
  - 0..3 = block address 1..4;
  - 4 = access command;
  - 5 = data.
- `data_0`, `data_1`  in  8  write data.
- `reject_0`, `reject_1`  out  1  1-cycle pulse: the write was dropped.
- `read_data_0`, `read_data_1`  out  8  drive `read_data` if granted, else 8'h00 (combinational).
- `interrupt_0`, `interrupt_1`  out  1  drive `interrupt` AND own grant (combinational).
- `terminal_count_0`, `terminal_count_1`  in  1  per-requester terminal count.
- `internal_data_bus`  out  8  registered data to drive.
- `write_block_address_1`..`write_block_address_4`, `write_access_command`, `write_data`  out  1  registered 1-cycle strobes to drive.
- `read_data`  in  8  from drive.
- `drive_busy`, `interrupt`  in  1  from drive.
- `terminal_count`  out  1  owner's `terminal_count_x`; 0 in IDLE (combinational).

## Operation
- States:
  - IDLE: no grant.
  - OWN0: `gnt_0` asserted.
  - OWN1: `gnt_1` asserted.
- Round-robin pointer `last`:
  - reset value 1, so requester 0 wins the first contention;
  - updated to x on every entry to OWNx.
- IDLE transitions:
  - only `req_x` high → OWNx;
  - both high → OWN(~last);
  - neither high → stay in IDLE.
- OWNx → IDLE when `release_ok` and either:
  - `req_x` low; or
  - hold counter == `max_hold_cycles`.
- `release_ok` is true when all of the following hold:
  - `drive_busy` = 0;
  - `cmd_pend` = 0;
  - no forwarded strobe is in flight this cycle.
- `cmd_pend` flag:
  - set when an access command is forwarded;
  - cleared on the first cycle `drive_busy` = 1, or after 2 cycles if busy never rises.
- Hold counter (16 bit):
  - increments in OWNx while all three hold: `drive_busy` = 0, `wr_x` = 0, `req_(~x)` = 1;
  - otherwise cleared to 0;
  - cleared on every state change;
  - saturates at `max_hold_cycles`.
- Writes:
  - `wr_x` with `gnt_x` = 1 and `sel_x` ≤ 5 → registered drive strobe plus `internal_data_bus` = `data_x`.
  - `wr_x` with `gnt_x` = 0, or `sel_x` > 5 → `reject_x` pulse; nothing is forwarded.
- A non-owner write never disturbs `internal_data_bus`.
- A forced release is identical to a voluntary release. The preempted requester simply re-requests.

## Timing
- Reset values:
  - state IDLE, `last` = 1;
  - all `gnt`, strobes and `reject` = 0;
  - `internal_data_bus` = 8'h00;
  - counter 0, `cmd_pend` 0.
- Grant latency:
  - `req_x` at cycle t in IDLE → `gnt_x` = 1 at t+1.
- Write latency:
  - `wr_x` at t with `gnt_x` = 1 → drive strobe and data at t+1, held exactly 1 cycle;
  - `reject_x` likewise appears at t+1.
- Release:
  - condition true at t → `gnt_x` = 0 at t+1 (IDLE);
  - next grant earliest at t+2, so there is always ≥ 1 idle cycle between owners.
- `req_x` drop while `drive_busy` = 1 → grant is held until the first cycle with `release_ok`.
- `wr_x` in the same cycle ownership ends → that write is still forwarded, since the grant was valid at t.
- Reset mid-transfer → immediate return to reset values; the drive's own reset is handled externally.

## Structure
- Package `kfmmc_arbiter_pkg` holds:
  - state enum (IDLE/OWN0/OWN1);
  - `sel` encodings (`SEL_BLOCK_ADDRESS_1`..`SEL_DATA`, `SEL_MAX` = 5).
- Single module; a sub-module is not needed. Write decode is a small `case` on the owner's `sel`.

## Test plan
- Reset → all outputs 0; then `req_0` = 1 → `gnt_0` = 1 one cycle later.
- `req_0` and `req_1` both rise at t from reset → `gnt_0` at t+1. Drop `req_0` at t+5 → `gnt_0` = 0 at t+6, `gnt_1` = 1 at t+7.
- OWN0, `wr_0` with `sel` = 4, data 8'h51 → `write_access_command` = 1 and bus = 8'h51 at t+1. Meanwhile `wr_1` → `reject_1` pulse and bus unchanged.
- OWN0 with `drive_busy` = 1 for 300 cycles and `req_0` dropped at cycle 10 → `gnt_0` is held until the cycle after busy falls.
- `max_hold_cycles` = 16, OWN0 idle with `req_1` high → `gnt_0` drops after 16 counted cycles and `gnt_1` rises one cycle after that. A `wr_0` at count 10 restarts the count.
- Drive `interrupt` = 1 and `read_data` = 8'hA5 in OWN1 → `interrupt_1` = 1, `read_data_1` = 8'hA5, `interrupt_0` = 0, `read_data_0` = 8'h00.

Source files
------------

// File: rtl/kfmmc_arbiter_pkg.sv
// Shared types and register-select encodings for the two-requester KFMMC drive arbiter.
package kfmmc_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  localparam logic [2:0] SEL_BLOCK_ADDRESS_1 = 3'd0;
  localparam logic [2:0] SEL_BLOCK_ADDRESS_2 = 3'd1;
  localparam logic [2:0] SEL_BLOCK_ADDRESS_3 = 3'd2;
  localparam logic [2:0] SEL_BLOCK_ADDRESS_4 = 3'd3;
  localparam logic [2:0] SEL_ACCESS_COMMAND  = 3'd4;
  localparam logic [2:0] SEL_DATA            = 3'd5;
  localparam logic [2:0] SEL_MAX             = 3'd5;

endpackage

// File: rtl/kfmmc_drive_arbiter.sv
// Round-robin arbiter sharing one KFMMC drive between two requesters; forwards only
// the owner's register writes and preempts an idle owner when the other side waits.
module kfmmc_drive_arbiter
  import kfmmc_arbiter_pkg::*;
#(
  parameter logic [15:0] max_hold_cycles = 16'd1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_0,
  input  logic       req_1,
  output logic       gnt_0,
  output logic       gnt_1,
  input  logic       wr_0,
  input  logic       wr_1,
  input  logic [2:0] sel_0,
  input  logic [2:0] sel_1,
  input  logic [7:0] data_0,
  input  logic [7:0] data_1,
  output logic       reject_0,
  output logic       reject_1,
  output logic [7:0] read_data_0,
  output logic [7:0] read_data_1,
  output logic       interrupt_0,
  output logic       interrupt_1,
  input  logic       terminal_count_0,
  input  logic       terminal_count_1,
  output logic [7:0] internal_data_bus,
  output logic       write_block_address_1,
  output logic       write_block_address_2,
  output logic       write_block_address_3,
  output logic       write_block_address_4,
  output logic       write_access_command,
  output logic       write_data,
  input  logic [7:0] read_data,
  input  logic       drive_busy,
  input  logic       interrupt,
  output logic       terminal_count
);

  arb_state_e  state_q, state_d;
  logic        last_q, last_d;
  logic [15:0] hold_q, hold_d;
  logic        cmd_pend_q, cmd_pend_d;
  logic        cmd_age_q, cmd_age_d;
  logic        gnt_0_q, gnt_1_q;
  logic [5:0]  strobe_q, strobe_d;
  logic [7:0]  bus_q, bus_d;
  logic        reject_0_q, reject_0_d;
  logic        reject_1_q, reject_1_d;

  logic        own_0, own_1, fwd_0, fwd_1, fwd_any;
  logic        release_ok, hold_cond, hold_hit;
  logic [2:0]  fwd_sel;
  logic [7:0]  fwd_data;

  always_comb begin
    own_0      = (state_q == ST_OWN0);
    own_1      = (state_q == ST_OWN1);
    fwd_0      = wr_0 && own_0 && (sel_0 <= SEL_MAX);
    fwd_1      = wr_1 && own_1 && (sel_1 <= SEL_MAX);
    fwd_any    = fwd_0 || fwd_1;
    fwd_sel    = fwd_1 ? sel_1 : sel_0;
    fwd_data   = fwd_1 ? data_1 : data_0;
    reject_0_d = wr_0 && !fwd_0;
    reject_1_d = wr_1 && !fwd_1;

    strobe_d = '0;
    bus_d    = bus_q;
    if (fwd_any) begin
      bus_d = fwd_data;
      case (fwd_sel)
        SEL_BLOCK_ADDRESS_1: strobe_d[0] = 1'b1;
        SEL_BLOCK_ADDRESS_2: strobe_d[1] = 1'b1;
        SEL_BLOCK_ADDRESS_3: strobe_d[2] = 1'b1;
        SEL_BLOCK_ADDRESS_4: strobe_d[3] = 1'b1;
        SEL_ACCESS_COMMAND:  strobe_d[4] = 1'b1;
        SEL_DATA:            strobe_d[5] = 1'b1;
        default:             strobe_d    = '0;
      endcase
    end

    // A just-issued command may not have raised busy yet; give it two cycles.
    cmd_pend_d = cmd_pend_q;
    cmd_age_d  = cmd_age_q;
    if (fwd_any && fwd_sel == SEL_ACCESS_COMMAND) begin
      cmd_pend_d = 1'b1;
      cmd_age_d  = 1'b0;
    end else if (cmd_pend_q) begin
      if (drive_busy || cmd_age_q) cmd_pend_d = 1'b0;
      else                         cmd_age_d  = 1'b1;
    end

    release_ok = !drive_busy && !cmd_pend_q && (strobe_q == 6'd0);
    hold_hit   = (hold_q == max_hold_cycles);
    hold_cond  = own_0 ? (!drive_busy && !wr_0 && req_1) :
                 own_1 ? (!drive_busy && !wr_1 && req_0) : 1'b0;

    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (req_0 && (!req_1 || last_q)) begin
          state_d = ST_OWN0;
          last_d  = 1'b0;
        end else if (req_1) begin
          state_d = ST_OWN1;
          last_d  = 1'b1;
        end
      end
      ST_OWN0: if (release_ok && (!req_0 || hold_hit)) state_d = ST_IDLE;
      ST_OWN1: if (release_ok && (!req_1 || hold_hit)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q || !hold_cond) hold_d = '0;
    else if (hold_hit)                    hold_d = hold_q;
    else                                  hold_d = hold_q + 16'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b1;
      hold_q     <= '0;
      cmd_pend_q <= 1'b0;
      cmd_age_q  <= 1'b0;
      gnt_0_q    <= 1'b0;
      gnt_1_q    <= 1'b0;
      strobe_q   <= '0;
      bus_q      <= 8'h00;
      reject_0_q <= 1'b0;
      reject_1_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      hold_q     <= hold_d;
      cmd_pend_q <= cmd_pend_d;
      cmd_age_q  <= cmd_age_d;
      gnt_0_q    <= (state_d == ST_OWN0);
      gnt_1_q    <= (state_d == ST_OWN1);
      strobe_q   <= strobe_d;
      bus_q      <= bus_d;
      reject_0_q <= reject_0_d;
      reject_1_q <= reject_1_d;
    end
  end

  assign gnt_0                 = gnt_0_q;
  assign gnt_1                 = gnt_1_q;
  assign reject_0              = reject_0_q;
  assign reject_1              = reject_1_q;
  assign internal_data_bus     = bus_q;
  assign write_block_address_1 = strobe_q[0];
  assign write_block_address_2 = strobe_q[1];
  assign write_block_address_3 = strobe_q[2];
  assign write_block_address_4 = strobe_q[3];
  assign write_access_command  = strobe_q[4];
  assign write_data            = strobe_q[5];
  assign read_data_0           = gnt_0_q ? read_data : 8'h00;
  assign read_data_1           = gnt_1_q ? read_data : 8'h00;
  assign interrupt_0           = interrupt & gnt_0_q;
  assign interrupt_1           = interrupt & gnt_1_q;
  assign terminal_count        = gnt_0_q ? terminal_count_0 :
                                 gnt_1_q ? terminal_count_1 : 1'b0;

endmodule

// File: tb/tb_kfmmc_drive_arbiter.sv
// Directed self-checking bench for kfmmc_drive_arbiter (max_hold_cycles = 16).
module tb_kfmmc_drive_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_0 = 1'b0, req_1 = 1'b0;
  logic       wr_0 = 1'b0, wr_1 = 1'b0;
  logic [2:0] sel_0 = 3'd0, sel_1 = 3'd0;
  logic [7:0] data_0 = 8'h00, data_1 = 8'h00;
  logic       terminal_count_0 = 1'b0, terminal_count_1 = 1'b0;
  logic [7:0] read_data = 8'h00;
  logic       drive_busy = 1'b0, interrupt = 1'b0;

  logic       gnt_0, gnt_1, reject_0, reject_1;
  logic [7:0] read_data_0, read_data_1;
  logic       interrupt_0, interrupt_1;
  logic [7:0] internal_data_bus;
  logic       write_block_address_1, write_block_address_2;
  logic       write_block_address_3, write_block_address_4;
  logic       write_access_command, write_data, terminal_count;

  int n_checks = 0;
  int n_errors = 0;

  kfmmc_drive_arbiter #(.max_hold_cycles(16'd16)) dut (
    .clock(clock), .reset(reset),
    .req_0(req_0), .req_1(req_1), .gnt_0(gnt_0), .gnt_1(gnt_1),
    .wr_0(wr_0), .wr_1(wr_1), .sel_0(sel_0), .sel_1(sel_1),
    .data_0(data_0), .data_1(data_1),
    .reject_0(reject_0), .reject_1(reject_1),
    .read_data_0(read_data_0), .read_data_1(read_data_1),
    .interrupt_0(interrupt_0), .interrupt_1(interrupt_1),
    .terminal_count_0(terminal_count_0), .terminal_count_1(terminal_count_1),
    .internal_data_bus(internal_data_bus),
    .write_block_address_1(write_block_address_1),
    .write_block_address_2(write_block_address_2),
    .write_block_address_3(write_block_address_3),
    .write_block_address_4(write_block_address_4),
    .write_access_command(write_access_command), .write_data(write_data),
    .read_data(read_data), .drive_busy(drive_busy), .interrupt(interrupt),
    .terminal_count(terminal_count)
  );

  always #5 clock = ~clock;

  logic [5:0] strobes;
  assign strobes = {write_data, write_access_command, write_block_address_4,
                    write_block_address_3, write_block_address_2, write_block_address_1};

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    // Reset state, with drive outputs active to prove masking while ungranted
    read_data = 8'h3C;
    interrupt = 1'b1;
    terminal_count_0 = 1'b1;
    step(); step();
    check_val("rst_gnt", {gnt_1, gnt_0}, 16'h0);
    check_val("rst_strobes", strobes, 16'h0);
    check_val("rst_bus", internal_data_bus, 16'h00);
    check_val("rst_reject", {reject_1, reject_0}, 16'h0);
    check_val("rst_rd0", read_data_0, 16'h00);
    check_val("rst_irq", {interrupt_1, interrupt_0}, 16'h0);
    check_val("rst_tc", terminal_count, 16'h0);
    reset = 1'b0;
    interrupt = 1'b0;
    step();

    // Single request: grant one cycle later, owner's terminal count routed
    req_0 = 1'b1;
    step();
    check_val("t1_gnt", {gnt_1, gnt_0}, 16'h1);
    check_val("t1_tc", terminal_count, 16'h1);
    req_0 = 1'b0;
    step();
    check_val("t1_release", {gnt_1, gnt_0}, 16'h0);
    terminal_count_0 = 1'b0;

    // Contention from reset: requester 0 wins, then 1 after an idle cycle
    do_reset();
    req_0 = 1'b1; req_1 = 1'b1;
    step();
    check_val("t2_gnt0", {gnt_1, gnt_0}, 16'h1);
    step(); step(); step(); step();
    req_0 = 1'b0;
    step();
    check_val("t2_idle", {gnt_1, gnt_0}, 16'h0);
    step();
    check_val("t2_gnt1", {gnt_1, gnt_0}, 16'h2);

    // OWN1 routing of drive outputs
    interrupt = 1'b1; read_data = 8'hA5; terminal_count_1 = 1'b1;
    #1;
    check_val("t6_irq1", interrupt_1, 16'h1);
    check_val("t6_rd1", read_data_1, 16'hA5);
    check_val("t6_irq0", interrupt_0, 16'h0);
    check_val("t6_rd0", read_data_0, 16'h00);
    check_val("t6_tc", terminal_count, 16'h1);
    interrupt = 1'b0; terminal_count_1 = 1'b0;

    // Owner writing an out-of-range select is rejected
    wr_1 = 1'b1; sel_1 = 3'd6; data_1 = 8'hCC;
    step();
    wr_1 = 1'b0;
    check_val("sel6_reject", {reject_1, reject_0}, 16'h2);
    check_val("sel6_strobes", strobes, 16'h0);
    check_val("sel6_bus", internal_data_bus, 16'h00);
    req_1 = 1'b0;
    step();
    check_val("t2_release1", {gnt_1, gnt_0}, 16'h0);

    // Owner command write forwarded, simultaneous non-owner write rejected
    req_0 = 1'b1;
    step();
    check_val("t3_gnt0", gnt_0, 16'h1);
    wr_0 = 1'b1; sel_0 = 3'd4; data_0 = 8'h51;
    wr_1 = 1'b1; sel_1 = 3'd5; data_1 = 8'hEE;
    step();
    wr_0 = 1'b0; wr_1 = 1'b0;
    check_val("t3_strobes", strobes, 16'h10);
    check_val("t3_bus", internal_data_bus, 16'h51);
    check_val("t3_reject", {reject_1, reject_0}, 16'h2);
    step();
    check_val("t3_strobe_1cyc", strobes, 16'h0);
    check_val("t3_reject_1cyc", {reject_1, reject_0}, 16'h0);
    wr_1 = 1'b1; sel_1 = 3'd0; data_1 = 8'h77;
    step();
    wr_1 = 1'b0;
    check_val("t3_nonowner_rej", reject_1, 16'h1);
    check_val("t3_bus_kept", internal_data_bus, 16'h51);

    // Busy drive holds grant after the owner drops its request
    drive_busy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (i == 10) req_0 = 1'b0;
      step();
      if (i == 11) check_val("t4_hold_early", gnt_0, 16'h1);
    end
    check_val("t4_hold_late", gnt_0, 16'h1);
    drive_busy = 1'b0;
    step();
    check_val("t4_release", gnt_0, 16'h0);

    // Reset mid-transfer clears everything without a clock edge
    req_0 = 1'b1;
    step();
    wr_0 = 1'b1; sel_0 = 3'd0; data_0 = 8'h9A;
    step();
    wr_0 = 1'b0;
    check_val("mr_strobe", strobes, 16'h01);
    check_val("mr_bus", internal_data_bus, 16'h9A);
    req_0 = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_val("mr_gnt", {gnt_1, gnt_0}, 16'h0);
    check_val("mr_bus0", internal_data_bus, 16'h00);
    check_val("mr_strobes0", strobes, 16'h0);
    step();
    reset = 1'b0;

    // Preemption of an idle owner after 16 counted cycles
    req_0 = 1'b1;
    step();
    check_val("pa_gnt0", gnt_0, 16'h1);
    req_1 = 1'b1;
    repeat (16) step();
    check_val("pa_last_cycle", {gnt_1, gnt_0}, 16'h1);
    step();
    check_val("pa_dropped", {gnt_1, gnt_0}, 16'h0);
    step();
    check_val("pa_gnt1", {gnt_1, gnt_0}, 16'h2);
    req_0 = 1'b0; req_1 = 1'b0;

    // A write at count 10 restarts the hold count
    do_reset();
    req_0 = 1'b1;
    step();
    req_1 = 1'b1;
    repeat (10) step();
    wr_0 = 1'b1; sel_0 = 3'd5; data_0 = 8'h5A;
    step();
    wr_0 = 1'b0;
    check_val("pb_wdata", strobes, 16'h20);
    check_val("pb_bus", internal_data_bus, 16'h5A);
    repeat (6) step();
    check_val("pb_not_yet", {gnt_1, gnt_0}, 16'h1);
    repeat (10) step();
    check_val("pb_last_cycle", {gnt_1, gnt_0}, 16'h1);
    step();
    check_val("pb_dropped", {gnt_1, gnt_0}, 16'h0);
    step();
    check_val("pb_gnt1", {gnt_1, gnt_0}, 16'h2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
